// File: rtl/snake_body_tracker.sv
// Snake body tracker for a 15x15 grid: ring-buffered body, occupancy bitmap and a
// three-state move sequencer (idle -> check -> commit).
// Optional build macro: SNAKE_WRAP_EN makes the head wrap at the grid edges instead of failing.
module snake_body_tracker (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         run,
    input  logic         step,
    input  logic         dir_valid,
    input  logic [1:0]   dir_req,
    input  logic [3:0]   food_x,
    input  logic [3:0]   food_y,
    output logic         collision,
    output logic [7:0]   length,
    output logic [3:0]   head_x,
    output logic [3:0]   head_y,
    output logic [224:0] cell_snake,
    output logic         ate,
    output logic         busy
);

    localparam int unsigned Cells = 225;
    localparam logic [3:0]  MaxCoord = 4'd14;
    localparam logic [7:0]  MaxLength = 8'd225;
    localparam logic [7:0]  LastPtr = 8'd224;
    // Initial body: tail (5,7), (6,7), head (7,7)
    localparam logic [7:0]  InitCell0 = 8'd110;
    localparam logic [7:0]  InitCell1 = 8'd111;
    localparam logic [7:0]  InitCell2 = 8'd112;
    localparam logic [224:0] InitMap = 225'b111 << 110;
    localparam logic [1:0]  DirUp = 2'd0;
    localparam logic [1:0]  DirRight = 2'd1;
    localparam logic [1:0]  DirDown = 2'd2;
    localparam logic [1:0]  DirLeft = 2'd3;

`ifdef SNAKE_WRAP_EN
    localparam logic WrapEn = 1'b1;
`else
    localparam logic WrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StCheck, StCommit} state_e;

    state_e         state_q, state_d;
    logic [7:0]     body_q [Cells];
    logic [7:0]     body_d [Cells];
    logic [7:0]     head_ptr_q, head_ptr_d;
    logic [7:0]     tail_ptr_q, tail_ptr_d;
    logic [7:0]     length_q, length_d;
    logic [3:0]     head_x_q, head_x_d;
    logic [3:0]     head_y_q, head_y_d;
    logic [224:0]   cell_q, cell_d;
    logic [1:0]     heading_q, heading_d;
    logic [1:0]     pending_q, pending_d;
    logic           collision_q, collision_d;
    logic [3:0]     nxt_x_q, nxt_x_d;
    logic [3:0]     nxt_y_q, nxt_y_d;
    logic [7:0]     nxt_cell_q, nxt_cell_d;
    logic           grow_q, grow_d;
    logic           fail_q, fail_d;

    logic [3:0]     cand_x, cand_y;
    logic           cand_edge;
    logic [7:0]     cand_cell;
    logic [7:0]     tail_cell;
    logic           cand_grow;
    logic           cand_fail;

    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return {4'd0, y} * 8'd15 + {4'd0, x};
    endfunction

    function automatic logic [7:0] ptr_inc(input logic [7:0] p);
        return (p == LastPtr) ? 8'd0 : p + 8'd1;
    endfunction

    // Candidate next head; coordinates always wrap so the bitmap lookup stays in range,
    // cand_edge records that the grid boundary was crossed.
    always_comb begin
        cand_x    = head_x_q;
        cand_y    = head_y_q;
        cand_edge = 1'b0;
        unique case (heading_q)
            DirUp: begin
                if (head_y_q == 4'd0) begin
                    cand_edge = 1'b1;
                    cand_y    = MaxCoord;
                end else begin
                    cand_y = head_y_q - 4'd1;
                end
            end
            DirRight: begin
                if (head_x_q == MaxCoord) begin
                    cand_edge = 1'b1;
                    cand_x    = 4'd0;
                end else begin
                    cand_x = head_x_q + 4'd1;
                end
            end
            DirDown: begin
                if (head_y_q == MaxCoord) begin
                    cand_edge = 1'b1;
                    cand_y    = 4'd0;
                end else begin
                    cand_y = head_y_q + 4'd1;
                end
            end
            default: begin
                if (head_x_q == 4'd0) begin
                    cand_edge = 1'b1;
                    cand_x    = MaxCoord;
                end else begin
                    cand_x = head_x_q - 4'd1;
                end
            end
        endcase
        cand_cell = cell_idx(cand_x, cand_y);
        tail_cell = body_q[tail_ptr_q];
        cand_grow = (cand_x == food_x) && (cand_y == food_y) && (length_q < MaxLength);
        // The tail cell is vacated in the same commit unless the snake grows
        cand_fail = (cand_edge && !WrapEn) ||
                    (cell_q[cand_cell] && !((cand_cell == tail_cell) && !cand_grow));
    end

    // Move sequencer next state, heading capture and body/bitmap update; init overrides all.
    always_comb begin
        state_d     = state_q;
        body_d      = body_q;
        head_ptr_d  = head_ptr_q;
        tail_ptr_d  = tail_ptr_q;
        length_d    = length_q;
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        cell_d      = cell_q;
        heading_d   = heading_q;
        pending_d   = pending_q;
        collision_d = collision_q;
        nxt_x_d     = nxt_x_q;
        nxt_y_d     = nxt_y_q;
        nxt_cell_d  = nxt_cell_q;
        grow_d      = grow_q;
        fail_d      = fail_q;

        // Reverse of a heading is the heading with bit 1 flipped
        if (dir_valid && (dir_req != (heading_q ^ 2'b10))) begin
            pending_d = dir_req;
        end

        unique case (state_q)
            StIdle: begin
                if (step && run && !collision_q) begin
                    state_d   = StCheck;
                    heading_d = pending_q;
                end
            end
            StCheck: begin
                state_d    = StCommit;
                nxt_x_d    = cand_x;
                nxt_y_d    = cand_y;
                nxt_cell_d = cand_cell;
                grow_d     = cand_grow;
                fail_d     = cand_fail;
            end
            default: begin
                state_d = StIdle;
                if (fail_q) begin
                    collision_d = 1'b1;
                end else begin
                    if (grow_q) begin
                        length_d = length_q + 8'd1;
                    end else begin
                        cell_d[tail_cell] = 1'b0;
                        tail_ptr_d        = ptr_inc(tail_ptr_q);
                    end
                    head_ptr_d         = ptr_inc(head_ptr_q);
                    body_d[head_ptr_d] = nxt_cell_q;
                    cell_d[nxt_cell_q] = 1'b1;
                    head_x_d           = nxt_x_q;
                    head_y_d           = nxt_y_q;
                end
            end
        endcase

        if (init) begin
            state_d     = StIdle;
            body_d[0]   = InitCell0;
            body_d[1]   = InitCell1;
            body_d[2]   = InitCell2;
            tail_ptr_d  = 8'd0;
            head_ptr_d  = 8'd2;
            length_d    = 8'd3;
            head_x_d    = 4'd7;
            head_y_d    = 4'd7;
            cell_d      = InitMap;
            heading_d   = DirRight;
            pending_d   = DirRight;
            collision_d = 1'b0;
            grow_d      = 1'b0;
            fail_d      = 1'b0;
        end
    end

    // State registers with synchronous reset to the same state init produces
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            body_q[0]   <= InitCell0;
            body_q[1]   <= InitCell1;
            body_q[2]   <= InitCell2;
            tail_ptr_q  <= 8'd0;
            head_ptr_q  <= 8'd2;
            length_q    <= 8'd3;
            head_x_q    <= 4'd7;
            head_y_q    <= 4'd7;
            cell_q      <= InitMap;
            heading_q   <= DirRight;
            pending_q   <= DirRight;
            collision_q <= 1'b0;
            nxt_x_q     <= 4'd0;
            nxt_y_q     <= 4'd0;
            nxt_cell_q  <= 8'd0;
            grow_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            body_q      <= body_d;
            tail_ptr_q  <= tail_ptr_d;
            head_ptr_q  <= head_ptr_d;
            length_q    <= length_d;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            cell_q      <= cell_d;
            heading_q   <= heading_d;
            pending_q   <= pending_d;
            collision_q <= collision_d;
            nxt_x_q     <= nxt_x_d;
            nxt_y_q     <= nxt_y_d;
            nxt_cell_q  <= nxt_cell_d;
            grow_q      <= grow_d;
            fail_q      <= fail_d;
        end
    end

    assign collision  = collision_q;
    assign length     = length_q;
    assign head_x     = head_x_q;
    assign head_y     = head_y_q;
    assign cell_snake = cell_q;
    assign busy       = (state_q != StIdle);
    assign ate        = (state_q == StCommit) && !fail_q && grow_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Testbench for snake_body_tracker: table of moves with expected head/length/flags,
// a queue-based body model for the bitmap, and hand sequences for init/busy corner cases.
module tb_snake_body_tracker;

    logic         clk = 1'b0;
    logic         reset, init, run, step, dir_valid;
    logic [1:0]   dir_req;
    logic [3:0]   food_x, food_y;
    logic         collision, ate, busy;
    logic [7:0]   length;
    logic [3:0]   head_x, head_y;
    logic [224:0] cell_snake;

    always #5 clk = ~clk;

    snake_body_tracker dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .run        (run),
        .step       (step),
        .dir_valid  (dir_valid),
        .dir_req    (dir_req),
        .food_x     (food_x),
        .food_y     (food_y),
        .collision  (collision),
        .length     (length),
        .head_x     (head_x),
        .head_y     (head_y),
        .cell_snake (cell_snake),
        .ate        (ate),
        .busy       (busy)
    );

    typedef struct {
        logic       dv;
        logic [1:0] dir;
        logic [3:0] fx;
        logic [3:0] fy;
        logic       moves;
        logic [3:0] hx;
        logic [3:0] hy;
        logic [7:0] len;
        logic       coll;
        logic       ate;
    } vec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    int   body_m[$];
    vec_t exp_q[$];
    vec_t tbl[10];

    function automatic vec_t mk(input logic dv, input logic [1:0] dir, input int fx, input int fy,
                                input logic moves, input int hx, input int hy, input int len,
                                input logic coll, input logic a);
        vec_t v;
        v.dv = dv; v.dir = dir; v.fx = 4'(fx); v.fy = 4'(fy); v.moves = moves;
        v.hx = 4'(hx); v.hy = 4'(hy); v.len = 8'(len); v.coll = coll; v.ate = a;
        return v;
    endfunction

    function automatic logic [224:0] model_map();
        logic [224:0] m = '0;
        foreach (body_m[i]) m[body_m[i]] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_init();
        body_m = {110, 111, 112};
    endtask

    task automatic check_init_state(input string tag);
        check({tag, "_head_x"}, 256'(head_x), 256'd7);
        check({tag, "_head_y"}, 256'(head_y), 256'd7);
        check({tag, "_length"}, 256'(length), 256'd3);
        check({tag, "_collision"}, 256'(collision), 256'd0);
        check({tag, "_busy"}, 256'(busy), 256'd0);
        check({tag, "_ate"}, 256'(ate), 256'd0);
        check({tag, "_bitmap"}, 256'(cell_snake), 256'(model_map()));
    endtask

    task automatic pulse_init();
        @(posedge clk); #1 init = 1'b1;
        @(posedge clk); #1 init = 1'b0;
        model_init();
    endtask

    // Load the direction request one cycle ahead of the step, then raise step
    task automatic drive_step(input vec_t v);
        @(posedge clk); #1;
        dir_valid = v.dv; dir_req = v.dir; food_x = v.fx; food_y = v.fy;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        step = 1'b1;
        exp_q.push_back(v);
    endtask

    // Watch busy/ate on falling edges; step drops after `hold` sampled rising edges
    task automatic collect(input string tag, input int hold);
        vec_t e;
        int   busy_cnt = 0;
        int   ate_cnt = 0;
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == hold) step = 1'b0;
            if (busy) begin
                busy_cnt++;
                if (ate) ate_cnt++;
            end else if (busy_cnt > 0) begin
                break;
            end
        end
        step = 1'b0;
        if (e.moves && !e.coll) begin
            body_m.push_back(int'(e.hy) * 15 + int'(e.hx));
            if (!e.ate) void'(body_m.pop_front());
        end
        check({tag, "_busy_cycles"}, 256'(busy_cnt), e.moves ? 256'd2 : 256'd0);
        check({tag, "_ate_pulses"}, 256'(ate_cnt), e.ate ? 256'd1 : 256'd0);
        check({tag, "_head_x"}, 256'(head_x), 256'(e.hx));
        check({tag, "_head_y"}, 256'(head_y), 256'(e.hy));
        check({tag, "_length"}, 256'(length), 256'(e.len));
        check({tag, "_collision"}, 256'(collision), 256'(e.coll));
        check({tag, "_bitmap"}, 256'(cell_snake), 256'(model_map()));
    endtask

    initial begin
        // Moves from the initial state: reverse request, eat, 2x2 loop at length 4,
        // grow to 5, same loop shape at length 5 collides, then a step is ignored.
        tbl[0] = mk(1'b1, 2'd3, 0, 0, 1'b1, 8, 7, 3, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 2'd0, 9, 7, 1'b1, 9, 7, 4, 1'b0, 1'b1);
        tbl[2] = mk(1'b1, 2'd2, 0, 0, 1'b1, 9, 8, 4, 1'b0, 1'b0);
        tbl[3] = mk(1'b1, 2'd3, 0, 0, 1'b1, 8, 8, 4, 1'b0, 1'b0);
        tbl[4] = mk(1'b1, 2'd0, 0, 0, 1'b1, 8, 7, 4, 1'b0, 1'b0);
        tbl[5] = mk(1'b1, 2'd0, 8, 6, 1'b1, 8, 6, 5, 1'b0, 1'b1);
        tbl[6] = mk(1'b1, 2'd1, 0, 0, 1'b1, 9, 6, 5, 1'b0, 1'b0);
        tbl[7] = mk(1'b1, 2'd2, 0, 0, 1'b1, 9, 7, 5, 1'b0, 1'b0);
        tbl[8] = mk(1'b1, 2'd3, 0, 0, 1'b1, 9, 7, 5, 1'b1, 1'b0);
        tbl[9] = mk(1'b0, 2'd0, 0, 0, 1'b0, 9, 7, 5, 1'b1, 1'b0);

        reset = 1'b1; init = 1'b0; run = 1'b0; step = 1'b0; dir_valid = 1'b0;
        dir_req = 2'd0; food_x = 4'd0; food_y = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_init();
        @(negedge clk);
        check_init_state("reset");

        // Step with run low is ignored
        drive_step(mk(1'b0, 2'd0, 0, 0, 1'b0, 7, 7, 3, 1'b0, 1'b0));
        collect("run_low", 1);
        run = 1'b1;

        foreach (tbl[i]) begin
            drive_step(tbl[i]);
            collect($sformatf("vec%0d", i), 1);
        end

        pulse_init();
        @(negedge clk);
        check_init_state("init_clears");

        // Eight steps right into the wall, then one more
        for (int k = 1; k <= 9; k++) begin
            vec_t v;
            if (k <= 7) begin
                v = mk(1'b0, 2'd0, 0, 0, 1'b1, 7 + k, 7, 3, 1'b0, 1'b0);
            end else begin
`ifdef SNAKE_WRAP_EN
                v = mk(1'b0, 2'd0, 0, 0, 1'b1, k - 8, 7, 3, 1'b0, 1'b0);
`else
                v = (k == 8) ? mk(1'b0, 2'd0, 0, 0, 1'b1, 14, 7, 3, 1'b1, 1'b0)
                             : mk(1'b0, 2'd0, 0, 0, 1'b0, 14, 7, 3, 1'b1, 1'b0);
`endif
            end
            drive_step(v);
            collect($sformatf("wall%0d", k), 1);
        end

        // Step held into the check cycle is not queued
        pulse_init();
        drive_step(mk(1'b0, 2'd0, 0, 0, 1'b1, 8, 7, 3, 1'b0, 1'b0));
        collect("busy_step", 2);
        begin
            int extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (busy) extra++;
            end
            check("busy_step_no_requeue", 256'(extra), 256'd0);
        end

        // Last valid request before the step wins: up then down from heading right
        pulse_init();
        @(posedge clk); #1 dir_valid = 1'b1; dir_req = 2'd0;
        @(posedge clk); #1 dir_req = 2'd2;
        drive_step(mk(1'b0, 2'd0, 0, 0, 1'b1, 7, 8, 3, 1'b0, 1'b0));
        collect("last_dir_wins", 1);

        // Init during check aborts the move
        pulse_init();
        @(posedge clk); #1 step = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_check_busy", 256'(busy), 256'd1);
        step = 1'b0;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check_init_state("abort_next");
        repeat (3) @(negedge clk);
        check_init_state("abort_settled");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
